// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma message controller.
// Holds the controller state encoding plus the character and key types.
package enigma_pkg;

   localparam int ALPHA = 26;

   typedef logic [4:0]  char_t;
   typedef logic [14:0] key_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      GET   = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      OUT   = 3'd5,
      DONE  = 3'd6
   } state_e;

endpackage

// File: rtl/enigma_msg_ctrl.sv
// Message-level sequencer for the enigma cipher core: loads the key, then
// streams each character through the core (or around it for non-letters).
module enigma_msg_ctrl #(
   parameter int CORE_LAT = 1,
   parameter int LEN_W    = 8,
   parameter int ALPHA    = enigma_pkg::ALPHA
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [14:0]      cfg_key,
   input  logic [1:0]       cfg_rA,
   input  logic [1:0]       cfg_rB,
   input  logic [1:0]       cfg_rC,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   input  logic [4:0]       in_char,
   output logic             in_ready,
   output logic             out_valid,
   output logic [4:0]       out_char,
   output logic             out_last,
   input  logic             out_ready,
   output logic [14:0]      core_key,
   output logic [1:0]       core_rA_cfg,
   output logic [1:0]       core_rB_cfg,
   output logic [1:0]       core_rC_cfg,
   output logic             core_load_key_cfg,
   output logic             core_new_char_pulse,
   output logic [4:0]       core_char_in,
   input  logic [4:0]       core_char_out,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);
   import enigma_pkg::*;

   localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

   state_e           state_q, state_d;
   key_t             key_q, key_d;
   logic [1:0]       ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   char_t            char_in_q, char_in_d;
   char_t            out_char_q, out_char_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [3:0]       wait_q, wait_d;
   logic             cfg_err_q, cfg_err_d;
   logic             collision;

   assign collision = (cfg_rA == cfg_rB) || (cfg_rA == cfg_rC) || (cfg_rB == cfg_rC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         key_q       <= '0;
         ra_q        <= '0;
         rb_q        <= '0;
         rc_q        <= '0;
         char_in_q   <= '0;
         out_char_q  <= '0;
         remaining_q <= '0;
         wait_q      <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         rc_q        <= rc_d;
         char_in_q   <= char_in_d;
         out_char_q  <= out_char_d;
         remaining_q <= remaining_d;
         wait_q      <= wait_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      ra_d        = ra_q;
      rb_d        = rb_q;
      rc_d        = rc_q;
      char_in_d   = char_in_q;
      out_char_d  = out_char_q;
      remaining_d = remaining_q;
      wait_d      = wait_q;
      cfg_err_d   = 1'b0;

      // Abort overrides every other transition once a message is underway.
      if (state_q != IDLE && abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  if (collision) begin
                     cfg_err_d = 1'b1;
                  end else begin
                     key_d       = cfg_key;
                     ra_d        = cfg_rA;
                     rb_d        = cfg_rB;
                     rc_d        = cfg_rC;
                     remaining_d = cfg_len;
                     state_d     = LOAD;
                  end
               end
            end
            LOAD: state_d = (remaining_q == '0) ? DONE : GET;
            GET: begin
               if (in_valid) begin
                  char_in_d = in_char;
                  if (int'(in_char) < ALPHA) begin
                     state_d = ISSUE;
                  end else begin
                     out_char_d = in_char;
                     state_d    = OUT;
                  end
               end
            end
            ISSUE: begin
               wait_d  = 4'(CORE_LAT);
               state_d = WAIT;
            end
            WAIT: begin
               if (wait_q <= 4'd1) begin
                  out_char_d = core_char_out;
                  state_d    = OUT;
               end else begin
                  wait_d = wait_q - 4'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  if (remaining_q != '0) begin
                     remaining_d = remaining_q - ONE_LEN;
                  end
                  state_d = (remaining_q <= ONE_LEN) ? DONE : GET;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Every control output is a decode of registered state only.
   assign in_ready            = (state_q == GET);
   assign out_valid           = (state_q == OUT);
   assign out_last            = (state_q == OUT) && (remaining_q == ONE_LEN);
   assign out_char            = out_char_q;
   assign core_key            = key_q;
   assign core_rA_cfg         = ra_q;
   assign core_rB_cfg         = rb_q;
   assign core_rC_cfg         = rc_q;
   assign core_load_key_cfg   = (state_q == LOAD);
   assign core_new_char_pulse = (state_q == ISSUE);
   assign core_char_in        = char_in_q;
   assign busy                = (state_q != IDLE);
   assign done                = (state_q == DONE);
   assign cfg_err             = cfg_err_q;

endmodule

// File: doc/enigma_msg_ctrl.md
Name: enigma_msg_ctrl

Overview:
- Message-level sequencer for the `enigma` cipher core.
- Accepts a start command carrying the key, rotor selection and message length, loads the key into the core, then streams characters through it one at a time.
- Input and output character streams use valid/ready handshakes; the controller drives every core control pin.
- Sits between the host/UART front-end and the `enigma` instance.

Parameters:
- CORE_LAT, 1, cycles from the core_new_char_pulse cycle until core_char_out is valid (1..15).
- LEN_W, 8, width of the message length and remaining-count.
- ALPHA, 26, number of legal symbols; codes >= ALPHA bypass the core.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled in IDLE only
- abort  in  1  cancel the current message
- cfg_key  in  15  initial rotor positions (3x5 bit)
- cfg_rA, cfg_rB, cfg_rC  in  2 each  rotor selection
- cfg_len  in  LEN_W  characters in the message
- in_valid  in  1  input character valid
- in_char  in  5  input character code
- in_ready  out  1  controller accepts in_char
- out_valid  out  1  output character valid
- out_char  out  5  ciphered (or bypassed) character
- out_last  out  1  marks the final character of the message
- out_ready  in  1  sink accepts out_char
- core_key  out  15  to enigma.key
- core_rA_cfg, core_rB_cfg, core_rC_cfg  out  2 each  to the enigma rotor cfg inputs
- core_load_key_cfg  out  1  to enigma.load_key_cfg
- core_new_char_pulse  out  1  to enigma.new_char_pulse
- core_char_in  out  5  to enigma.char_in
- core_char_out  in  5  from enigma.char_out
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse when a message completes
- cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (asynchronous, active-high):
  - state returns to IDLE.
  - All outputs go to 0, including core_key, the core cfg pins and out_char.
  - The remaining-count clears to 0.
- Control outputs are decoded from the registered state. No combinational path exists from in_valid or out_ready to any core pin.
- IDLE:
  - If start=1 and abort=0, the cfg inputs are checked for rotor collisions.
  - If any two of cfg_rA, cfg_rB, cfg_rC are equal, cfg_err pulses in the next cycle and the FSM stays in IDLE.
  - Otherwise cfg_key, the rotor cfgs and cfg_len are latched into the core_* and remaining registers, and the FSM goes to LOAD.
- LOAD (1 cycle):
  - core_load_key_cfg=1.
  - Next state is DONE if remaining=0, else GET.
- GET:
  - in_ready=1.
  - On in_valid, in_char is latched into core_char_in.
  - If in_char < ALPHA, go to ISSUE; otherwise go to OUT with out_char=in_char. A bypassed character does not step the rotors.
- ISSUE (1 cycle):
  - core_new_char_pulse=1.
  - The wait counter loads CORE_LAT and the FSM goes to WAIT.
- WAIT:
  - Lasts CORE_LAT cycles; core_char_in is held stable throughout.
  - On the final WAIT cycle, core_char_out is captured into out_char and the FSM goes to OUT.
- OUT:
  - out_valid=1 and out_last=(remaining==1).
  - out_char, out_valid and out_last stay stable until out_ready.
  - On out_ready, remaining decrements. If it reaches 0, go to DONE; else go to GET.
- DONE (1 cycle): done=1, then return to IDLE. core_key and the cfg pins keep their last values.
- Latency: from in_valid&in_ready to out_valid is 2+CORE_LAT cycles. Best-case throughput is one character per 3+CORE_LAT cycles.
- abort:
  - In any non-IDLE state, the FSM returns to IDLE on the next edge.
  - out_valid and in_ready drop and no done pulse is issued.
  - core_load_key_cfg and core_new_char_pulse are never raised after abort is sampled.
- Boundary cases:
  - start while busy is ignored.
  - start and abort together in IDLE: abort wins and nothing is latched.
  - cfg_len=0: the key is still loaded, then done is issued.
  - cfg_len at its maximum (2^LEN_W-1) must complete without wrap-around.
  - remaining never underflows.

Decomposition:
- Shared package `enigma_pkg`:
  - typedef for the state enum (IDLE, LOAD, GET, ISSUE, WAIT, OUT, DONE).
  - typedef for the 5-bit character.
  - typedef for the 15-bit key.
  - ALPHA = 26.
- No sub-module: the FSM, the wait counter and the remaining-count live in this block.

Test Plan:
- Stub core returning (char_in+1)%26 one cycle after the pulse (CORE_LAT=1). Start with key=0, rA=0, rB=1, rC=2, len=1, then send in_char=0 -> core_load_key_cfg high in cycle 1; out_char=1 with out_last=1 at cycle 5; done one cycle after out_ready.
- len=3, chars 0, 25, 30 -> outputs 1, 0, 30. The pulse count is 2, since 30 bypasses the core. out_last is set on the third output only.
- start with rA=1, rB=1, rC=2 -> cfg_err pulses once, busy stays 0, and no core_load_key_cfg is raised.
- Backpressure: hold out_ready=0 for 10 cycles -> out_char is stable, in_ready=0, and no new pulse is issued.
- abort asserted during WAIT with len=4 -> IDLE next cycle, no done; a following start with len=1 completes normally.
- Assert reset mid-message in OUT -> all outputs read 0 immediately, before any clock edge; cfg_len=0 afterwards -> LOAD then done, with no pulse.
